// File: rtl/cvxif_latency_exec.sv
// CV-X-IF coprocessor execution unit: per-class latency, single op in flight,
// in-order result FIFO drained by a valid/ready handshake.
module cvxif_latency_exec #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ID_WIDTH  = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LAT_ADD   = 0,
  parameter int unsigned LAT_MULTI = 1,
  parameter int unsigned LAT_R3    = 1,
  parameter int unsigned LAT_XOR   = 2,
  parameter int unsigned LAT_OR    = 0,
  parameter int unsigned LAT_AND   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [3:0]          issue_opcode_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic [XLEN-1:0]     issue_rs3_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o,
  output logic                result_exc_o,
  output logic                busy_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_NOP        = 4'd1;
  localparam logic [3:0] OP_ADD        = 4'd2;
  localparam logic [3:0] OP_DOUBLE_RS1 = 4'd3;
  localparam logic [3:0] OP_DOUBLE_RS2 = 4'd4;
  localparam logic [3:0] OP_ADD_MULTI  = 4'd5;
  localparam logic [3:0] OP_ADD_RS3_R4 = 4'd6;
  localparam logic [3:0] OP_ADD_RS3_R  = 4'd7;
  localparam logic [3:0] OP_XOR        = 4'd8;
  localparam logic [3:0] OP_OR         = 4'd9;
  localparam logic [3:0] OP_AND        = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [XLEN-1:0]     data;
    logic                we;
    logic                exc;
  } res_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  res_t             r_pend;
  res_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  res_t       w_res;
  res_t       w_push_res;
  logic [3:0] w_lat;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Result and latency are resolved at accept; the result is held until its push.
  always_comb begin
    w_res      = '0;
    w_res.id   = issue_id_i;
    w_res.rd   = issue_rd_i;
    w_res.we   = 1'b1;
    w_lat      = 4'd0;
    case (issue_opcode_i)
      OP_NOP:        w_res.we = 1'b0;
      OP_ADD:        begin w_res.data = issue_rs1_i + issue_rs2_i; w_lat = 4'(LAT_ADD); end
      OP_DOUBLE_RS1: begin w_res.data = issue_rs1_i + issue_rs1_i; w_lat = 4'(LAT_ADD); end
      OP_DOUBLE_RS2: begin w_res.data = issue_rs2_i + issue_rs2_i; w_lat = 4'(LAT_ADD); end
      OP_ADD_MULTI:  begin w_res.data = issue_rs1_i + issue_rs2_i; w_lat = 4'(LAT_MULTI); end
      OP_ADD_RS3_R4,
      OP_ADD_RS3_R:  begin
        w_res.data = issue_rs1_i + issue_rs2_i + issue_rs3_i;
        w_lat      = 4'(LAT_R3);
      end
      OP_XOR:        begin w_res.data = issue_rs1_i ^ issue_rs2_i; w_lat = 4'(LAT_XOR); end
      OP_OR:         begin w_res.data = issue_rs1_i | issue_rs2_i; w_lat = 4'(LAT_OR); end
      OP_AND:        begin w_res.data = issue_rs1_i & issue_rs2_i; w_lat = 4'(LAT_AND); end
      default:       begin w_res.we = 1'b0; w_res.exc = 1'b1; end
    endcase
  end

  // Space is judged on the pre-pop count, so a same-cycle pop never admits an accept.
  assign issue_ready_o  = (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH)) && !flush_i;
  assign w_accept       = issue_valid_i && issue_ready_o;
  assign w_push         = ((r_state == S_IDLE) && w_accept && (w_lat == 4'd0)) ||
                          ((r_state == S_EXEC) && (r_cnt == 4'd0));
  assign w_push_res     = (r_state == S_EXEC) ? r_pend : w_res;
  assign result_valid_o = (r_count != '0);
  assign w_pop          = result_valid_o && result_ready_i;
  assign busy_o         = (r_state == S_EXEC) || result_valid_o;

  assign result_id_o    = r_mem[r_rd_ptr].id;
  assign result_rd_o    = r_mem[r_rd_ptr].rd;
  assign result_data_o  = r_mem[r_rd_ptr].data;
  assign result_we_o    = r_mem[r_rd_ptr].we;
  assign result_exc_o   = r_mem[r_rd_ptr].exc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_pend   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_lat != 4'd0)) begin
            r_pend  <= w_res;
            r_cnt   <= w_lat - 4'd1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_res;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
